// File: rtl/telestrat_audio_pkg.sv
// telestrat_audio_pkg: shared mode/state types and stereo-select decode for the PSG mixer
package telestrat_audio_pkg;
  typedef enum logic [1:0] {MONO, ABC, ACB} stereo_mode_e;
  typedef enum logic [1:0] {RUN, FADE_OUT, SWITCH, FADE_IN} mix_state_e;
  function automatic stereo_mode_e decode_mode(input logic [1:0] stereo);
    return stereo == 2'b01 ? ABC : stereo == 2'b10 ? ACB : MONO;
  endfunction
endpackage

// File: rtl/audio_lpf.sv
// audio_lpf: one-pole low-pass y += (x - y) >>> SHIFT, updating only when en is high
module audio_lpf #(
  parameter int SHIFT = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] x,
  output logic [15:0] y
);
  logic [15:0] y_q, y_d;
  logic signed [16:0] diff, step;
  // step always lies between 0 and x - y, so the sum stays inside 16 bits
  always_comb begin
    diff = $signed({1'b0, x}) - $signed({1'b0, y_q});
    step = diff >>> SHIFT;
    y_d = en ? y_q + 16'(step) : y_q;
  end
  always_ff @(posedge clk_sys)
    if (reset) y_q <= '0;
    else y_q <= y_d;
  assign y = y_q;
endmodule

// File: rtl/psg_stereo_mixer.sv
// psg_stereo_mixer: registered PSG stereo mix with click-free mode fades and per-channel low-pass
module psg_stereo_mixer
  import telestrat_audio_pkg::*;
#(
  parameter int FADE_BITS = 4,
  parameter int LPF_SHIFT = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_sample,
  input  logic [7:0]  psg_a,
  input  logic [7:0]  psg_b,
  input  logic [7:0]  psg_c,
  input  logic [9:0]  psg_mono,
  input  logic [1:0]  stereo,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        audio_valid
);
  localparam int PW = 17 + FADE_BITS;
  localparam logic [FADE_BITS:0] GMAX = {1'b1, {FADE_BITS{1'b0}}};
  stereo_mode_e mode_q, mode_d, req_mode;
  mix_state_e state_q, state_d;
  logic [FADE_BITS:0] gain_q, gain_d, gain_s_q;
  logic [9:0] a10, b10, c10, raw_l_d, raw_r_d, raw_l_q, raw_r_q;
  logic s1_q, valid_q;
  logic [15:0] scaled_l, scaled_r;
  function automatic logic [15:0] scale(input logic [9:0] raw, input logic [FADE_BITS:0] g);
    logic [PW-1:0] p;
    p = (PW'({raw, 6'b0}) * PW'(g)) >> FADE_BITS;
    return |p[PW-1:16] ? 16'hFFFF : p[15:0];
  endfunction
  always_comb begin
    a10 = {2'b0, psg_a};
    b10 = {2'b0, psg_b};
    c10 = {2'b0, psg_c};
    req_mode = decode_mode(stereo);
    raw_l_d = mode_q == ABC ? a10 + b10 : mode_q == ACB ? a10 + c10 : psg_mono;
    raw_r_d = mode_q == MONO ? psg_mono : c10 + b10;
    scaled_l = scale(raw_l_q, gain_s_q);
    scaled_r = scale(raw_r_q, gain_s_q);
  end
  // fade FSM; a reversal in FADE_IN turns around from the current gain
  always_comb begin
    state_d = state_q;
    gain_d = gain_q;
    mode_d = mode_q;
    if (ce_sample)
      case (state_q)
        RUN: state_d = req_mode != mode_q ? FADE_OUT : RUN;
        FADE_OUT:
          if (gain_q == '0) state_d = SWITCH;
          else gain_d = gain_q - 1'b1;
        SWITCH: begin
          mode_d = req_mode;
          state_d = FADE_IN;
        end
        default:
          if (req_mode != mode_q) begin
            state_d = FADE_OUT;
            gain_d = gain_q == '0 ? gain_q : gain_q - 1'b1;
          end else if (gain_q == GMAX) state_d = RUN;
          else gain_d = gain_q + 1'b1;
      endcase
  end
  always_ff @(posedge clk_sys)
    if (reset) begin
      mode_q <= req_mode;
      state_q <= FADE_IN;
      gain_q <= '0;
      gain_s_q <= '0;
      raw_l_q <= '0;
      raw_r_q <= '0;
      s1_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      state_q <= state_d;
      gain_q <= gain_d;
      s1_q <= ce_sample;
      valid_q <= s1_q;
      if (ce_sample) begin
        raw_l_q <= raw_l_d;
        raw_r_q <= raw_r_d;
        gain_s_q <= gain_q;
      end
    end
  audio_lpf #(.SHIFT(LPF_SHIFT)) u_lpf_l (
    .clk_sys(clk_sys), .reset(reset), .en(s1_q), .x(scaled_l), .y(audio_l)
  );
  audio_lpf #(.SHIFT(LPF_SHIFT)) u_lpf_r (
    .clk_sys(clk_sys), .reset(reset), .en(s1_q), .x(scaled_r), .y(audio_r)
  );
  assign audio_valid = valid_q;
endmodule

// File: tb/tb_psg_stereo_mixer.sv
// tb_psg_stereo_mixer: directed vectors and fade sequences for the PSG stereo mixer
module tb_psg_stereo_mixer;
  logic clk = 1'b0, rst, ce;
  logic [7:0] a, b, c;
  logic [9:0] mono;
  logic [1:0] st;
  logic [15:0] l0, r0, l1, r1;
  logic v0, v1;
  int n_chk = 0, n_fail = 0, vcnt = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (v1) vcnt++;
  psg_stereo_mixer #(.FADE_BITS(4), .LPF_SHIFT(0)) u0 (
    .clk_sys(clk), .reset(rst), .ce_sample(ce), .psg_a(a), .psg_b(b), .psg_c(c),
    .psg_mono(mono), .stereo(st), .audio_l(l0), .audio_r(r0), .audio_valid(v0)
  );
  psg_stereo_mixer u1 (
    .clk_sys(clk), .reset(rst), .ce_sample(ce), .psg_a(a), .psg_b(b), .psg_c(c),
    .psg_mono(mono), .stereo(st), .audio_l(l1), .audio_r(r1), .audio_valid(v1)
  );
  typedef struct {
    string name;
    logic [1:0] st;
    logic [7:0] a, b, c;
    logic [9:0] m;
    logic [15:0] el, er;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic rst_go(input logic [1:0] s);
    st = s;
    ce = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask
  task automatic strobe();
    ce = 1'b1;
    @(posedge clk); #1 ce = 1'b0;
    chk("valid_early", {15'b0, v0}, 16'd0);
    @(posedge clk); #1;
    chk("valid", {15'b0, v0}, 16'd1);
    repeat (2) @(posedge clk);
    #1 chk("valid_drop", {15'b0, v0}, 16'd0);
  endtask
  task automatic to_run(input logic [1:0] s);
    rst_go(s);
    repeat (17) strobe();
  endtask
  initial begin
    int prev, d, maxstep, c0;
    {a, b, c, mono, ce} = '0;
    vecs[0] = '{"abc",     2'b01, 8'h10, 8'h20, 8'h30, 10'h000, 16'h0C00, 16'h1400};
    vecs[1] = '{"acb",     2'b10, 8'h10, 8'h20, 8'h30, 10'h000, 16'h1000, 16'h1400};
    vecs[2] = '{"mono00",  2'b00, 8'h10, 8'h20, 8'h30, 10'h3FF, 16'hFFC0, 16'hFFC0};
    vecs[3] = '{"mono11",  2'b11, 8'hAA, 8'h55, 8'h01, 10'h155, 16'h5540, 16'h5540};
    vecs[4] = '{"abc_max", 2'b01, 8'hFF, 8'hFF, 8'hFF, 10'h000, 16'h7F80, 16'h7F80};
    vecs[5] = '{"acb_mix", 2'b10, 8'h01, 8'hFF, 8'h80, 10'h2AA, 16'h2040, 16'h5FC0};
    // reset state, then gain ramp and filtered settle
    a = 8'h40; b = 8'h40; c = 8'h40;
    rst_go(2'b01);
    chk("rst_l", l0, 16'h0); chk("rst_r", r0, 16'h0); chk("rst_v", {15'b0, v0}, 16'd0);
    chk("rst_l1", l1, 16'h0);
    c0 = vcnt;
    for (int k = 1; k <= 17; k++) begin
      strobe();
      chk($sformatf("ramp%0d", k), l0, 16'((k - 1) * 16'h200));
    end
    repeat (40) strobe();
    chk("lpf_settle", {15'b0, (l1 >= 16'h1FFC && l1 <= 16'h2000)}, 16'd1);
    chk("lpf_valid_cnt", 16'(vcnt - c0), 16'd57);
    // steady-state mixes in RUN
    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; mono = vecs[i].m;
      to_run(vecs[i].st);
      chk({vecs[i].name, "_l"}, l0, vecs[i].el);
      chk({vecs[i].name, "_r"}, r0, vecs[i].er);
    end
    // back-to-back strobes through the stage 2 pipeline
    a = 8'h01; ce = 1'b1;
    @(posedge clk); #1 a = 8'h02;
    @(posedge clk); #1 chk("b2b0", l0, 16'h2040); chk("b2b_v0", {15'b0, v0}, 16'd1); a = 8'h03;
    @(posedge clk); #1 ce = 1'b0; chk("b2b1", l0, 16'h2080); chk("b2b_r", r0, 16'h5FC0);
    @(posedge clk); #1 chk("b2b2", l0, 16'h20C0); chk("b2b_v2", {15'b0, v0}, 16'd1);
    @(posedge clk); #1 chk("b2b_vend", {15'b0, v0}, 16'd0);
    // ABC -> mono fade out, switch, fade in
    a = 8'h80; b = 8'h80; c = 8'h80; mono = 10'h3FF;
    to_run(2'b01);
    chk("f3_run_l", l0, 16'h4000); chk("f3_run_r", r0, 16'h4000);
    st = 2'b00; prev = 16'h4000; maxstep = 0;
    for (int k = 0; k <= 35; k++) begin
      strobe();
      d = int'(l0) - prev;
      if (d < 0) d = -d;
      if (d > maxstep) maxstep = d;
      prev = int'(l0);
      if (k == 16) chk("f3_gain1", l0, 16'h0400);
      if (k == 17) chk("f3_zero", l0, 16'h0);
    end
    chk("f3_step", {15'b0, maxstep <= 16'h1000}, 16'd1);
    chk("f3_end_l", l0, 16'hFFC0); chk("f3_end_r", r0, 16'hFFC0);
    // stereo toggles during fade out: only the switch-time value counts
    a = 8'h10; b = 8'h20; c = 8'h30; mono = 10'h000;
    to_run(2'b01);
    st = 2'b00;
    for (int k = 0; k <= 35; k++) begin
      if (k == 10) st = 2'b10;
      if (k == 14) st = 2'b01;
      strobe();
      if (k == 10) chk("f4_gain7", l0, 16'h0540);
      if (k == 17) chk("f4_zero", l0, 16'h0);
    end
    chk("f4_mode_l", l0, 16'h0C00); chk("f4_mode_r", r0, 16'h1400);
    // reversal during fade in
    rst_go(2'b01);
    for (int k = 1; k <= 14; k++) begin
      if (k == 6) st = 2'b10;
      strobe();
      if (k == 6) chk("f5_g5", l0, 16'h03C0);
      if (k == 7) chk("f5_g4", l0, 16'h0300);
      if (k == 8) chk("f5_g3", l0, 16'h0240);
    end
    chk("f5_new_l", l0, 16'h0100); chk("f5_new_r", r0, 16'h0140);
    // reset with coincident strobe during fade out
    to_run(2'b01);
    st = 2'b10;
    repeat (5) strobe();
    ce = 1'b1; rst = 1'b1;
    @(posedge clk); #1 ce = 1'b0; rst = 1'b0;
    chk("f6_l", l0, 16'h0); chk("f6_r", r0, 16'h0); chk("f6_v", {15'b0, v0}, 16'd0);
    @(posedge clk); #1 chk("f6_v2", {15'b0, v0}, 16'd0);
    strobe();
    chk("f6_g0", l0, 16'h0);
    strobe();
    chk("f6_g1_l", l0, 16'h0100); chk("f6_g1_r", r0, 16'h0140);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
